// File: rtl/symbol_pkg.sv
// symbol_pkg: shared slot record, shape encoding and distance helper for the symbol overlay
package symbol_pkg;
  localparam int CW = 10;
  localparam int COLW = 8;
  localparam int GW = CW + 3;
  typedef enum logic [1:0] {PLUS, CROSS, BOX, RSVD} shape_e;
  typedef struct packed {
    logic [CW-1:0] cx;
    logic [CW-1:0] cy;
    logic [CW-1:0] size;
    logic [CW-1:0] thick;
    shape_e shape;
    logic [COLW-1:0] color;
    logic blink;
    logic enable;
  } slot_t;
  function automatic logic signed [GW-1:0] absd(input logic [CW-1:0] a, input logic [CW-1:0] b);
    logic signed [GW-1:0] d;
    d = signed'({3'b000, a}) - signed'({3'b000, b});
    return d[GW-1] ? -d : d;
  endfunction
endpackage

// File: rtl/symbol_overlay_if.sv
// symbol_overlay_if: slot programming, pixel stream and hit result bundle
interface symbol_overlay_if import symbol_pkg::*; #(parameter int N_SLOTS = 9) ();
  localparam int IW = N_SLOTS > 1 ? $clog2(N_SLOTS) : 1;
  logic wr_en_i;
  logic [IW-1:0] wr_idx_i;
  logic [CW-1:0] wr_cx_i;
  logic [CW-1:0] wr_cy_i;
  logic [CW-1:0] wr_size_i;
  logic [CW-1:0] wr_thick_i;
  logic [1:0] wr_shape_i;
  logic [COLW-1:0] wr_color_i;
  logic wr_blink_i;
  logic wr_enable_i;
  logic clear_i;
  logic frame_tick_i;
  logic pix_valid_i;
  logic [CW-1:0] x_i;
  logic [CW-1:0] y_i;
  logic pix_valid_o;
  logic hit_o;
  logic [IW-1:0] slot_o;
  logic [COLW-1:0] color_o;
  logic blink_phase_o;
  modport master (
    output wr_en_i, wr_idx_i, wr_cx_i, wr_cy_i, wr_size_i, wr_thick_i, wr_shape_i,
           wr_color_i, wr_blink_i, wr_enable_i, clear_i, frame_tick_i, pix_valid_i, x_i, y_i,
    input pix_valid_o, hit_o, slot_o, color_o, blink_phase_o
  );
  modport slave (
    input wr_en_i, wr_idx_i, wr_cx_i, wr_cy_i, wr_size_i, wr_thick_i, wr_shape_i,
          wr_color_i, wr_blink_i, wr_enable_i, clear_i, frame_tick_i, pix_valid_i, x_i, y_i,
    output pix_valid_o, hit_o, slot_o, color_o, blink_phase_o
  );
endinterface

// File: rtl/symbol_hit.sv
// symbol_hit: combinational geometry test of one pixel against one slot's shape
module symbol_hit import symbol_pkg::*; (
  input logic [CW-1:0] x,
  input logic [CW-1:0] y,
  input slot_t slot,
  output logic hit
);
  logic signed [GW-1:0] dx, dy, hs, ht, inner, dd;
  logic in_sq;
  logic unused_fields;
  assign unused_fields = ^{slot.color, slot.blink, slot.enable};
  always_comb begin
    dx = absd(x, slot.cx);
    dy = absd(y, slot.cy);
    hs = signed'({3'b000, slot.size >> 1});
    ht = signed'({3'b000, slot.thick >> 1});
    inner = hs - signed'({3'b000, slot.thick});
    dd = dx >= dy ? dx - dy : dy - dx;
    in_sq = dx <= hs && dy <= hs;
    // a negative inner bound never matches, so a thick box renders filled
    hit = slot.shape == PLUS  ? (dx <= hs && dy <= ht) || (dx <= ht && dy <= hs) :
          slot.shape == CROSS ? in_sq && dd <= ht :
          slot.shape == BOX   ? in_sq && !(dx <= inner && dy <= inner) : 1'b0;
  end
endmodule

// File: rtl/symbol_overlay.sv
// symbol_overlay: N-slot symbol renderer with 2-cycle hit/priority pipeline and blink timer
module symbol_overlay import symbol_pkg::*; #(
  parameter int N_SLOTS = 9,
  parameter int BLINK_FRAMES = 30
) (
  input logic clk,
  input logic rst_n,
  symbol_overlay_if.slave bus
);
  localparam int IW = N_SLOTS > 1 ? $clog2(N_SLOTS) : 1;
  localparam int BW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  slot_t slots [N_SLOTS];
  logic [N_SLOTS-1:0] raw, vis_q;
  logic [COLW-1:0] col_q [N_SLOTS];
  logic v1, phase, any;
  logic [IW-1:0] win;
  logic [COLW-1:0] col;
  logic [BW-1:0] cnt;
  for (genvar i = 0; i < N_SLOTS; i++) begin : g_hit
    symbol_hit u_hit (.x(bus.x_i), .y(bus.y_i), .slot(slots[i]), .hit(raw[i]));
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < N_SLOTS; i++) slots[i] <= '0;
    end else begin
      for (int i = 0; i < N_SLOTS; i++) begin
        if (bus.wr_en_i && bus.wr_idx_i == IW'(i))
          slots[i] <= '{cx: bus.wr_cx_i, cy: bus.wr_cy_i, size: bus.wr_size_i,
                        thick: bus.wr_thick_i, shape: shape_e'(bus.wr_shape_i),
                        color: bus.wr_color_i, blink: bus.wr_blink_i, enable: bus.wr_enable_i};
        if (bus.clear_i) slots[i].enable <= 1'b0;
      end
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      phase <= 1'b0;
    end else if (bus.frame_tick_i) begin
      cnt <= cnt == BW'(BLINK_FRAMES - 1) ? '0 : cnt + 1'b1;
      phase <= cnt == BW'(BLINK_FRAMES - 1) ? ~phase : phase;
    end
  // colours are captured with the hit bits so a later write cannot recolour an in-flight pixel
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v1 <= 1'b0;
      vis_q <= '0;
      for (int i = 0; i < N_SLOTS; i++) col_q[i] <= '0;
    end else begin
      v1 <= bus.pix_valid_i;
      for (int i = 0; i < N_SLOTS; i++) begin
        vis_q[i] <= bus.pix_valid_i & raw[i] & slots[i].enable & ~(slots[i].blink & phase);
        col_q[i] <= slots[i].color;
      end
    end
  always_comb begin
    any = 1'b0;
    win = '0;
    col = '0;
    for (int i = N_SLOTS - 1; i >= 0; i--)
      if (vis_q[i]) begin
        any = 1'b1;
        win = IW'(i);
        col = col_q[i];
      end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.pix_valid_o <= 1'b0;
      bus.hit_o <= 1'b0;
      bus.slot_o <= '0;
      bus.color_o <= '0;
    end else begin
      bus.pix_valid_o <= v1;
      bus.hit_o <= v1 & any;
      bus.slot_o <= v1 && any ? win : '0;
      bus.color_o <= v1 && any ? col : '0;
    end
  assign bus.blink_phase_o = phase;
endmodule

// File: tb/tb_symbol_overlay.sv
// tb_symbol_overlay: directed checks of geometry, priority, write timing, blink, clear and reset
module tb_symbol_overlay;
  import symbol_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  symbol_overlay_if #(.N_SLOTS(9)) bus ();
  symbol_overlay #(.N_SLOTS(9), .BLINK_FRAMES(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic wr(input logic [3:0] idx, input logic [9:0] cx, input logic [9:0] cy,
                    input logic [9:0] sz, input logic [9:0] th, input logic [1:0] sh,
                    input logic [7:0] c, input logic bl, input logic en, input logic clr);
    @(negedge clk);
    bus.wr_en_i = 1'b1; bus.wr_idx_i = idx; bus.wr_cx_i = cx; bus.wr_cy_i = cy;
    bus.wr_size_i = sz; bus.wr_thick_i = th; bus.wr_shape_i = sh; bus.wr_color_i = c;
    bus.wr_blink_i = bl; bus.wr_enable_i = en; bus.clear_i = clr;
    @(negedge clk);
    bus.wr_en_i = 1'b0; bus.clear_i = 1'b0;
  endtask

  task automatic send(input int x, input int y);
    @(negedge clk);
    bus.pix_valid_i = 1'b1; bus.x_i = 10'(x); bus.y_i = 10'(y);
    @(negedge clk);
    bus.pix_valid_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic tick();
    @(negedge clk);
    bus.frame_tick_i = 1'b1;
    @(negedge clk);
    bus.frame_tick_i = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({bus.pix_valid_o, bus.hit_o, bus.slot_o, bus.color_o, bus.blink_phase_o} !== 15'b0) begin
      errors++;
      $display("FAIL reset: got pv=%b hit=%b slot=%0d color=%h phase=%b, expected all 0",
               bus.pix_valid_o, bus.hit_o, bus.slot_o, bus.color_o, bus.blink_phase_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_plus();
    int xs[6] = '{115, 100, 116, 100, 99, 98};
    int ys[6] = '{100, 85, 100, 84, 101, 102};
    bit eh[6] = '{1, 1, 0, 0, 1, 0};
    wr(0, 100, 100, 30, 3, 2'd0, 8'h11, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    bus.pix_valid_i = 1'b1; bus.x_i = 10'd115; bus.y_i = 10'd100;
    @(negedge clk);
    bus.pix_valid_i = 1'b0;
    checks++;
    if ({bus.pix_valid_o, bus.hit_o} !== 2'b00) begin
      errors++;
      $display("FAIL plus_latency1: got pv=%b hit=%b, expected pv=0 hit=0", bus.pix_valid_o, bus.hit_o);
    end
    @(negedge clk);
    checks++;
    if ({bus.pix_valid_o, bus.hit_o, bus.slot_o, bus.color_o} !== {1'b1, 1'b1, 4'd0, 8'h11}) begin
      errors++;
      $display("FAIL plus_latency2: got pv=%b hit=%b slot=%0d color=%h, expected pv=1 hit=1 slot=0 color=11",
               bus.pix_valid_o, bus.hit_o, bus.slot_o, bus.color_o);
    end
    for (int k = 0; k < 6; k++) begin
      send(xs[k], ys[k]);
      checks++;
      if ({bus.pix_valid_o, bus.hit_o, bus.slot_o, bus.color_o} !== {1'b1, eh[k], 4'd0, eh[k] ? 8'h11 : 8'h00}) begin
        errors++;
        $display("FAIL plus(%0d,%0d): got pv=%b hit=%b slot=%0d color=%h, expected hit=%b slot=0 color=%h",
                 xs[k], ys[k], bus.pix_valid_o, bus.hit_o, bus.slot_o, bus.color_o, eh[k], eh[k] ? 8'h11 : 8'h00);
      end
    end
  endtask

  task automatic test_cross_box();
    int xs[6] = '{210, 210, 310, 309, 308, 300};
    int ys[6] = '{110, 100, 100, 100, 100, 100};
    bit eh[6] = '{1, 0, 1, 1, 0, 0};
    logic [3:0] es[6] = '{4'd1, 4'd0, 4'd2, 4'd2, 4'd0, 4'd0};
    logic [7:0] ec[6] = '{8'h22, 8'h00, 8'h44, 8'h44, 8'h00, 8'h00};
    wr(1, 200, 100, 30, 2, 2'd1, 8'h22, 1'b0, 1'b1, 1'b0);
    wr(2, 300, 100, 20, 2, 2'd2, 8'h44, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 6; k++) begin
      send(xs[k], ys[k]);
      checks++;
      if ({bus.pix_valid_o, bus.hit_o, bus.slot_o, bus.color_o} !== {1'b1, eh[k], es[k], ec[k]}) begin
        errors++;
        $display("FAIL cross_box(%0d,%0d): got pv=%b hit=%b slot=%0d color=%h, expected hit=%b slot=%0d color=%h",
                 xs[k], ys[k], bus.pix_valid_o, bus.hit_o, bus.slot_o, bus.color_o, eh[k], es[k], ec[k]);
      end
    end
  endtask

  task automatic test_priority();
    wr(3, 100, 100, 10, 2, 2'd0, 8'h33, 1'b0, 1'b1, 1'b0);
    send(100, 100);
    checks++;
    if ({bus.hit_o, bus.slot_o, bus.color_o} !== {1'b1, 4'd0, 8'h11}) begin
      errors++;
      $display("FAIL priority: got hit=%b slot=%0d color=%h, expected hit=1 slot=0 color=11",
               bus.hit_o, bus.slot_o, bus.color_o);
    end
    @(negedge clk);
    bus.wr_en_i = 1'b1; bus.wr_idx_i = 4'd0; bus.wr_cx_i = 10'd100; bus.wr_cy_i = 10'd100;
    bus.wr_size_i = 10'd30; bus.wr_thick_i = 10'd3; bus.wr_shape_i = 2'd0; bus.wr_color_i = 8'h11;
    bus.wr_blink_i = 1'b0; bus.wr_enable_i = 1'b0;
    bus.pix_valid_i = 1'b1; bus.x_i = 10'd100; bus.y_i = 10'd100;
    @(negedge clk);
    bus.wr_en_i = 1'b0;
    @(negedge clk);
    bus.pix_valid_i = 1'b0;
    checks++;
    if ({bus.hit_o, bus.slot_o, bus.color_o} !== {1'b1, 4'd0, 8'h11}) begin
      errors++;
      $display("FAIL write_same_edge: got hit=%b slot=%0d color=%h, expected hit=1 slot=0 color=11",
               bus.hit_o, bus.slot_o, bus.color_o);
    end
    @(negedge clk);
    checks++;
    if ({bus.hit_o, bus.slot_o, bus.color_o} !== {1'b1, 4'd3, 8'h33}) begin
      errors++;
      $display("FAIL write_next_pixel: got hit=%b slot=%0d color=%h, expected hit=1 slot=3 color=33",
               bus.hit_o, bus.slot_o, bus.color_o);
    end
  endtask

  task automatic test_blink();
    int xs[4] = '{115, 100, 115, 100};
    bit eh[4] = '{0, 1, 1, 1};
    logic [3:0] es[4] = '{4'd0, 4'd3, 4'd0, 4'd0};
    logic [7:0] ec[4] = '{8'h00, 8'h33, 8'h11, 8'h11};
    wr(0, 100, 100, 30, 3, 2'd0, 8'h11, 1'b1, 1'b1, 1'b0);
    send(115, 100);
    checks++;
    if ({bus.hit_o, bus.slot_o, bus.color_o, bus.blink_phase_o} !== {1'b1, 4'd0, 8'h11, 1'b0}) begin
      errors++;
      $display("FAIL blink_phase0: got hit=%b slot=%0d color=%h phase=%b, expected hit=1 slot=0 color=11 phase=0",
               bus.hit_o, bus.slot_o, bus.color_o, bus.blink_phase_o);
    end
    tick();
    tick();
    checks++;
    if (bus.blink_phase_o !== 1'b1) begin
      errors++;
      $display("FAIL blink_toggle1: got phase=%b, expected 1", bus.blink_phase_o);
    end
    for (int k = 0; k < 2; k++) begin
      send(xs[k], 100);
      checks++;
      if ({bus.pix_valid_o, bus.hit_o, bus.slot_o, bus.color_o} !== {1'b1, eh[k], es[k], ec[k]}) begin
        errors++;
        $display("FAIL blink_hidden(%0d,100): got pv=%b hit=%b slot=%0d color=%h, expected hit=%b slot=%0d color=%h",
                 xs[k], bus.pix_valid_o, bus.hit_o, bus.slot_o, bus.color_o, eh[k], es[k], ec[k]);
      end
    end
    tick();
    @(negedge clk);
    bus.frame_tick_i = 1'b1; bus.pix_valid_i = 1'b1; bus.x_i = 10'd115; bus.y_i = 10'd100;
    @(negedge clk);
    bus.frame_tick_i = 1'b0; bus.pix_valid_i = 1'b0;
    checks++;
    if (bus.blink_phase_o !== 1'b0) begin
      errors++;
      $display("FAIL blink_toggle2: got phase=%b, expected 0", bus.blink_phase_o);
    end
    @(negedge clk);
    checks++;
    if ({bus.pix_valid_o, bus.hit_o} !== 2'b10) begin
      errors++;
      $display("FAIL blink_tick_pixel: got pv=%b hit=%b, expected pv=1 hit=0 (pre-toggle phase)",
               bus.pix_valid_o, bus.hit_o);
    end
    for (int k = 2; k < 4; k++) begin
      send(xs[k], 100);
      checks++;
      if ({bus.pix_valid_o, bus.hit_o, bus.slot_o, bus.color_o} !== {1'b1, eh[k], es[k], ec[k]}) begin
        errors++;
        $display("FAIL blink_shown(%0d,100): got pv=%b hit=%b slot=%0d color=%h, expected hit=%b slot=%0d color=%h",
                 xs[k], bus.pix_valid_o, bus.hit_o, bus.slot_o, bus.color_o, eh[k], es[k], ec[k]);
      end
    end
  endtask

  task automatic test_edge_clear();
    int xs[6] = '{0, 1020, 100, 0, 500, 210};
    int ys[6] = '{400, 400, 100, 400, 500, 110};
    bit eh[6] = '{1, 0, 0, 0, 0, 0};
    wr(4, 5, 400, 30, 3, 2'd0, 8'h55, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 6; k++) begin
      if (k == 2) wr(5, 500, 500, 30, 3, 2'd0, 8'h66, 1'b0, 1'b1, 1'b1);
      send(xs[k], ys[k]);
      checks++;
      if ({bus.pix_valid_o, bus.hit_o, bus.slot_o, bus.color_o} !== {1'b1, eh[k], eh[k] ? 4'd4 : 4'd0, eh[k] ? 8'h55 : 8'h00}) begin
        errors++;
        $display("FAIL edge_clear(%0d,%0d): got pv=%b hit=%b slot=%0d color=%h, expected hit=%b",
                 xs[k], ys[k], bus.pix_valid_o, bus.hit_o, bus.slot_o, bus.color_o, eh[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    wr(0, 100, 100, 30, 3, 2'd0, 8'h11, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    bus.pix_valid_i = 1'b1; bus.x_i = 10'd100; bus.y_i = 10'd100;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.pix_valid_o, bus.hit_o, bus.slot_o, bus.color_o} !== {1'b1, 1'b1, 4'd0, 8'h11}) begin
      errors++;
      $display("FAIL stream_before_reset: got pv=%b hit=%b slot=%0d color=%h, expected pv=1 hit=1 slot=0 color=11",
               bus.pix_valid_o, bus.hit_o, bus.slot_o, bus.color_o);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.pix_valid_o, bus.hit_o, bus.slot_o, bus.color_o, bus.blink_phase_o} !== 15'b0) begin
      errors++;
      $display("FAIL async_reset: got pv=%b hit=%b slot=%0d color=%h phase=%b, expected all 0",
               bus.pix_valid_o, bus.hit_o, bus.slot_o, bus.color_o, bus.blink_phase_o);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1; bus.pix_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.pix_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_flush: got pv=%b, expected 0", bus.pix_valid_o);
    end
    send(100, 100);
    checks++;
    if ({bus.pix_valid_o, bus.hit_o, bus.slot_o, bus.color_o} !== {1'b1, 1'b0, 4'd0, 8'h00}) begin
      errors++;
      $display("FAIL after_reset: got pv=%b hit=%b slot=%0d color=%h, expected pv=1 hit=0 slot=0 color=00",
               bus.pix_valid_o, bus.hit_o, bus.slot_o, bus.color_o);
    end
  endtask

  initial begin
    bus.wr_en_i = 1'b0; bus.wr_idx_i = '0; bus.wr_cx_i = '0; bus.wr_cy_i = '0;
    bus.wr_size_i = '0; bus.wr_thick_i = '0; bus.wr_shape_i = '0; bus.wr_color_i = '0;
    bus.wr_blink_i = 1'b0; bus.wr_enable_i = 1'b0; bus.clear_i = 1'b0; bus.frame_tick_i = 1'b0;
    bus.pix_valid_i = 1'b0; bus.x_i = '0; bus.y_i = '0;
    test_reset();
    test_plus();
    test_cross_box();
    test_priority();
    test_blink();
    test_edge_clear();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/symbol_overlay.md
Name: symbol_overlay

Overview:
- Parametrised multi-slot symbol renderer for the VGA pixel path. Holds N programmable symbol slots, each with centre, size, thickness, shape (plus, cross, box outline), colour and blink enable.
- For each incoming pixel coordinate it reports hit, winning slot and colour, with a fixed 2-cycle pipeline latency.
- Sits between the VGA timing generator and the final colour mux. Replaces per-symbol combinational instances.

Parameters:
- N_SLOTS, 9, number of symbol slots (1..16).
- CW, 10, coordinate/size width in bits.
- COLW, 8, colour index width.
- BLINK_FRAMES, 30, frame ticks per blink half-period (≥1).

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  reset, asynchronous, active-low.
- wr_en_i  in  1  slot write strobe.
- wr_idx_i  in  $clog2(N_SLOTS)  slot to write; values ≥N_SLOTS are ignored.
- wr_cx_i, wr_cy_i  in  CW  symbol centre.
- wr_size_i  in  CW  total symbol extent.
- wr_thick_i  in  CW  stroke thickness.
- wr_shape_i  in  2  0=PLUS, 1=CROSS, 2=BOX, 3=reserved (never hits).
- wr_color_i  in  COLW  colour index.
- wr_blink_i  in  1  slot participates in blinking.
- wr_enable_i  in  1  slot visible.
- clear_i  in  1  disable all slots.
- frame_tick_i  in  1  one-cycle pulse per frame.
- pix_valid_i  in  1  pixel coordinate valid.
- x_i, y_i  in  CW  current pixel.
- pix_valid_o  out  1  pix_valid_i delayed 2 cycles.
- hit_o  out  1  pixel lies on a visible symbol.
- slot_o  out  $clog2(N_SLOTS)  winning slot.
- color_o  out  COLW  winning slot colour.
- blink_phase_o  out  1  current blink phase (1 = blinking slots hidden).

Behaviour:
- Reset (async, rst_n=0):
  - All slots disabled; all slot fields 0.
  - Outputs 0; blink counter 0; blink_phase_o=0.
  - Mid-stream reset flushes the pipeline; pix_valid_o stays 0 until 2 cycles after the first valid pixel following reset release.
- Slot registers:
  - On a clk edge with wr_en_i=1, the slot fields are written.
  - clear_i=1 clears every enable bit and has priority over a same-cycle write.
  - A pixel sampled on the same edge as a write uses the old slot values. The new values apply from the next pixel.
- Geometry (per slot, signed arithmetic at CW+3 bits, no wrap at screen edges):
  - hs = size>>1, ht = thick>>1, dx = |x-cx|, dy = |y-cy|.
  - PLUS: (dx≤hs && dy≤ht) || (dx≤ht && dy≤hs). Inclusive bounds.
  - CROSS: dx≤hs && dy≤hs && |dx-dy|≤ht.
  - BOX: (dx≤hs && dy≤hs) && !(dx≤hs-thick && dy≤hs-thick). If thick>hs the box is filled.
- Visibility: a slot is visible when enable=1 and !(blink=1 && blink_phase=1).
- Pipeline:
  - Stage 1 registers per-slot visible-hit bits plus valid.
  - Stage 2 priority-encodes, with the lowest slot index winning, and registers the outputs.
  - When pix_valid_o=0 or there is no hit: hit_o=0, slot_o=0, color_o=0.
- Blink:
  - The counter increments on frame_tick_i.
  - On reaching BLINK_FRAMES-1 with a tick, the counter returns to 0 and blink_phase toggles.
  - blink_phase is sampled into stage 1 alongside the pixel.
  - frame_tick_i asserted with pix_valid_i=1 is legal: that pixel sees the pre-toggle phase.
- No backpressure: one pixel per cycle, always accepted.

Decomposition:
- symbol_pkg:
  - shape_e enum (PLUS, CROSS, BOX, RSVD).
  - slot_t packed struct {cx, cy, size, thick, shape, color, blink, enable}, parametrised via localparam widths matching the defaults.
- Sub-module symbol_hit: purely combinational geometry for one slot (x, y, slot_t → hit), instantiated N_SLOTS times via generate.
- symbol_overlay owns the slot register file, blink counter, pipeline and priority encoder.

Test Plan:
- PLUS geometry: slot0 PLUS cx=100, cy=100, size=30, thick=3, enabled.
  - Hits at (115,100) and (100,85).
  - Misses at (116,100) and (100,84).
  - (99,101) hit; (98,102) miss.
  - Each response appears exactly 2 cycles after the input.
- CROSS and BOX geometry:
  - Slot1 CROSS at (200,100), size=30, thick=2: (210,110) hit, (210,100) miss.
  - Slot2 BOX at (300,100), size=20, thick=2: (310,100) hit, (309,100) hit, (308,100) miss, (300,100) miss.
- Priority and write timing:
  - Slots 0 and 3 overlap at (100,100), colours 0x11 and 0x33 → color_o=0x11, slot_o=0.
  - Write slot0 enable=0 on the same edge a pixel is sampled: that pixel still reports slot0; the next pixel reports slot3.
- Blink, BLINK_FRAMES=2, slot0 blink=1:
  - After 2 frame_tick_i pulses, blink_phase_o=1 and hits on slot0 vanish.
  - After 2 more pulses, hits reappear.
  - A non-blink slot is unaffected throughout.
- Edge and clear:
  - Slot at cx=5, size=30: pixel (0,cy) hits, with no wrap to x=1020.
  - clear_i together with wr_en_i: all slots are disabled, so no hits.
- Reset mid-operation:
  - Assert rst_n=0 while pix_valid_i streams: all outputs 0 asynchronously.
  - After release, no hits until slots are rewritten.
  - pix_valid_o resumes 2 cycles after valid input.
